// File: rtl/wolverine_mc_arbiter_if.sv
// Wolverine memory-controller port bundle.
// Arbiter drives it as master; the MC side is slave.
interface wolverine_mc_arbiter_if #(
  parameter int RTNCTL_W = 32
);
  logic                mc_req_valid;
  logic [RTNCTL_W-1:0] mc_req_rtnctl;
  logic [63:0]         mc_req_data;
  logic [47:0]         mc_req_addr;
  logic [1:0]          mc_req_size;
  logic [2:0]          mc_req_cmd;
  logic [3:0]          mc_req_scmd;
  logic                mc_req_stall;
  logic                mc_res_valid;
  logic [2:0]          mc_res_cmd;
  logic [3:0]          mc_res_scmd;
  logic [63:0]         mc_res_data;
  logic [RTNCTL_W-1:0] mc_res_rtnctl;
  logic                mc_res_stall;
  logic                mc_req_flush;
  logic                mc_res_flush_ok;

  modport master (
    output mc_req_valid, mc_req_rtnctl, mc_req_data,
    output mc_req_addr, mc_req_size, mc_req_cmd,
    output mc_req_scmd, mc_res_stall, mc_req_flush,
    input  mc_req_stall, mc_res_valid, mc_res_cmd,
    input  mc_res_scmd, mc_res_data, mc_res_rtnctl,
    input  mc_res_flush_ok
  );

  modport slave (
    input  mc_req_valid, mc_req_rtnctl, mc_req_data,
    input  mc_req_addr, mc_req_size, mc_req_cmd,
    input  mc_req_scmd, mc_res_stall, mc_req_flush,
    output mc_req_stall, mc_res_valid, mc_res_cmd,
    output mc_res_scmd, mc_res_data, mc_res_rtnctl,
    output mc_res_flush_ok
  );
endinterface

// File: rtl/wolverine_mc_arbiter.sv
// Round-robin share of one Wolverine MC port among NUM_REQ requesters.
// Tags rtnctl with the requester id, routes responses, serialises flushes.
module wolverine_mc_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int RTNCTL_W = 32,
  parameter int MAX_OUT  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*RTNCTL_W-1:0] req_rtnctl,
  input  logic [NUM_REQ*64-1:0]       req_data,
  input  logic [NUM_REQ*48-1:0]       req_addr,
  input  logic [NUM_REQ*2-1:0]        req_size,
  input  logic [NUM_REQ*3-1:0]        req_cmd,
  input  logic [NUM_REQ*4-1:0]        req_scmd,
  output logic [NUM_REQ-1:0]          req_stall,
  input  logic [NUM_REQ-1:0]          req_flush,
  output logic [NUM_REQ-1:0]          res_flush_ok,
  output logic [NUM_REQ-1:0]          res_valid,
  output logic [2:0]                  res_cmd,
  output logic [3:0]                  res_scmd,
  output logic [63:0]                 res_data,
  output logic [RTNCTL_W-1:0]         res_rtnctl,
  input  logic [NUM_REQ-1:0]          res_stall,
  wolverine_mc_arbiter_if.master      mc,
  output logic                        err_unroutable
);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int LOW_W = RTNCTL_W - ID_W;
  localparam logic [CNT_W:0] MAX_L = (CNT_W+1)'(MAX_OUT);
  localparam logic [ID_W:0] NREQ_L = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {F_IDLE, F_ISSUE, F_WAIT} fstate_t;

  logic                q_valid;
  logic [RTNCTL_W-1:0] q_rtnctl;
  logic [63:0]         q_data;
  logic [47:0]         q_addr;
  logic [1:0]          q_size;
  logic [2:0]          q_cmd;
  logic [3:0]          q_scmd;
  logic [ID_W-1:0]     ptr;
  logic [CNT_W-1:0]    out_cnt [NUM_REQ];
  logic [NUM_REQ-1:0]  pending;
  logic [ID_W-1:0]     flush_sel;
  fstate_t             state, state_n;

  logic [ID_W-1:0]    held_id, win, tag, low_idx;
  logic               load, accept, found;
  logic               routable, tag_stall, consume;
  logic               any_pend, can_start;
  logic               flush_done;
  logic [NUM_REQ-1:0] held, elig, grant, inc, dec, done_mask;
  logic [LOW_W-1:0]   n_lo;
  logic [63:0]        n_data;
  logic [47:0]        n_addr;
  logic [1:0]         n_size;
  logic [2:0]         n_cmd;
  logic [3:0]         n_scmd;
  logic               unused_rtnctl_hi;

  assign held_id = q_rtnctl[RTNCTL_W-1 -: ID_W];
  assign load    = !q_valid || !mc.mc_req_stall;
  assign accept  = q_valid && !mc.mc_req_stall;

  // Eligibility counts the held request so a requester never exceeds MAX_OUT
  always_comb begin
    held = '0;
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      held[i] = q_valid && (held_id == ID_W'(i));
      elig[i] = req_valid[i] && !pending[i] &&
        (({1'b0, out_cnt[i]} + {{CNT_W{1'b0}}, held[i]}) < MAX_L);
    end
  end

  // Round-robin pick starting at ptr
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (load && !found && elig[i] &&
            (((int'(ptr) + k) % NUM_REQ) == i)) begin
          grant[i] = 1'b1;
          win      = ID_W'(i);
          found    = 1'b1;
        end
      end
    end
  end

  assign req_stall = ~grant;

  // Select the winner's request fields
  always_comb begin
    n_lo   = '0;
    n_data = '0;
    n_addr = '0;
    n_size = '0;
    n_cmd  = '0;
    n_scmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        n_lo   = req_rtnctl[i*RTNCTL_W +: LOW_W];
        n_data = req_data[i*64 +: 64];
        n_addr = req_addr[i*48 +: 48];
        n_size = req_size[i*2 +: 2];
        n_cmd  = req_cmd[i*3 +: 3];
        n_scmd = req_scmd[i*4 +: 4];
      end
    end
  end

  // Tag bits of requester rtnctl are overwritten by the id
  always_comb begin
    unused_rtnctl_hi = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      unused_rtnctl_hi = unused_rtnctl_hi ^
        (^req_rtnctl[i*RTNCTL_W + LOW_W +: ID_W]);
    end
  end

  // Output request register and round-robin pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      q_valid  <= 1'b0;
      q_rtnctl <= '0;
      q_data   <= '0;
      q_addr   <= '0;
      q_size   <= '0;
      q_cmd    <= '0;
      q_scmd   <= '0;
      ptr      <= '0;
    end else if (load) begin
      q_valid  <= found;
      q_rtnctl <= {win, n_lo};
      q_data   <= n_data;
      q_addr   <= n_addr;
      q_size   <= n_size;
      q_cmd    <= n_cmd;
      q_scmd   <= n_scmd;
      if (found) begin
        ptr <= (win == LAST) ? '0 : win + 1'b1;
      end
    end
  end

  assign mc.mc_req_valid  = q_valid;
  assign mc.mc_req_rtnctl = q_rtnctl;
  assign mc.mc_req_data   = q_data;
  assign mc.mc_req_addr   = q_addr;
  assign mc.mc_req_size   = q_size;
  assign mc.mc_req_cmd    = q_cmd;
  assign mc.mc_req_scmd   = q_scmd;

  assign tag      = mc.mc_res_rtnctl[RTNCTL_W-1 -: ID_W];
  assign routable = {1'b0, tag} < NREQ_L;

  // Route the response by tag; unroutable tags are simply consumed
  always_comb begin
    res_valid = '0;
    tag_stall = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag == ID_W'(i)) begin
        res_valid[i] = mc.mc_res_valid;
        tag_stall    = res_stall[i];
      end
    end
  end

  assign mc.mc_res_stall = mc.mc_res_valid && routable && tag_stall;
  assign consume = mc.mc_res_valid && routable && !tag_stall;
  assign res_cmd    = mc.mc_res_cmd;
  assign res_scmd   = mc.mc_res_scmd;
  assign res_data   = mc.mc_res_data;
  assign res_rtnctl = {{ID_W{1'b0}}, mc.mc_res_rtnctl[LOW_W-1:0]};

  // Per-id issue/retire strobes
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      inc[i] = accept && (held_id == ID_W'(i));
      dec[i] = consume && (tag == ID_W'(i));
    end
  end

  // Outstanding counters; issue and retire together cancel
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) out_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (inc[i] && !dec[i]) begin
          out_cnt[i] <= out_cnt[i] + 1'b1;
        end else if (dec[i] && !inc[i] && out_cnt[i] != '0) begin
          out_cnt[i] <= out_cnt[i] - 1'b1;
        end
      end
    end
  end

  // Sticky flag for responses carrying a tag with no requester
  always_ff @(posedge clock) begin
    if (reset) begin
      err_unroutable <= 1'b0;
    end else if (mc.mc_res_valid && !routable) begin
      err_unroutable <= 1'b1;
    end
  end

  // Lowest pending flush index
  always_comb begin
    low_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = ID_W'(i);
    end
  end

  assign any_pend  = |pending;
  assign can_start = any_pend && !(q_valid && held_id == low_idx);

  // Flush FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= F_IDLE;
    else       state <= state_n;
  end

  // Flush FSM next state
  always_comb begin
    state_n = state;
    unique case (state)
      F_IDLE:  if (can_start) state_n = F_ISSUE;
      F_ISSUE: state_n = F_WAIT;
      F_WAIT:  if (mc.mc_res_flush_ok) state_n = F_IDLE;
      default: state_n = F_IDLE;
    endcase
  end

  // Flush FSM outputs
  always_comb begin
    mc.mc_req_flush = (state == F_ISSUE);
    flush_done      = (state == F_WAIT) && mc.mc_res_flush_ok;
    done_mask       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      done_mask[i] = flush_done && (flush_sel == ID_W'(i));
    end
  end

  // Pending flush set, selection and completion pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      pending      <= '0;
      flush_sel    <= '0;
      res_flush_ok <= '0;
    end else begin
      pending      <= (pending | req_flush) & ~done_mask;
      res_flush_ok <= done_mask;
      if (state == F_IDLE && can_start) flush_sel <= low_idx;
    end
  end
endmodule

// File: tb/tb_wolverine_mc_arbiter.sv
// Directed bench for wolverine_mc_arbiter.
// Second instance with NUM_REQ=3 covers the unroutable tag.
module tb_wolverine_mc_arbiter;
  localparam int N  = 4;
  localparam int RW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int g;

  logic [N-1:0]    req_valid, req_stall, req_flush;
  logic [N-1:0]    res_flush_ok, res_valid, res_stall;
  logic [N*RW-1:0] req_rtnctl;
  logic [N*64-1:0] req_data;
  logic [N*48-1:0] req_addr;
  logic [N*2-1:0]  req_size;
  logic [N*3-1:0]  req_cmd;
  logic [N*4-1:0]  req_scmd;
  logic [2:0]      res_cmd;
  logic [3:0]      res_scmd;
  logic [63:0]     res_data;
  logic [RW-1:0]   res_rtnctl;
  logic            err;

  logic [2:0]    req_stall3, res_flush_ok3, res_valid3;
  logic [2:0]    res_cmd3;
  logic [3:0]    res_scmd3;
  logic [63:0]   res_data3;
  logic [RW-1:0] res_rtnctl3;
  logic          err3;

  wolverine_mc_arbiter_if #(.RTNCTL_W(RW)) mc ();
  wolverine_mc_arbiter_if #(.RTNCTL_W(RW)) mc3 ();

  wolverine_mc_arbiter #(
    .NUM_REQ(N), .ID_W(2), .RTNCTL_W(RW), .MAX_OUT(16)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_rtnctl(req_rtnctl),
    .req_data(req_data), .req_addr(req_addr),
    .req_size(req_size), .req_cmd(req_cmd),
    .req_scmd(req_scmd), .req_stall(req_stall),
    .req_flush(req_flush), .res_flush_ok(res_flush_ok),
    .res_valid(res_valid), .res_cmd(res_cmd),
    .res_scmd(res_scmd), .res_data(res_data),
    .res_rtnctl(res_rtnctl), .res_stall(res_stall),
    .mc(mc.master), .err_unroutable(err)
  );

  wolverine_mc_arbiter #(
    .NUM_REQ(3), .ID_W(2), .RTNCTL_W(RW), .MAX_OUT(16)
  ) dut3 (
    .clock(clock), .reset(reset),
    .req_valid('0), .req_rtnctl('0),
    .req_data('0), .req_addr('0),
    .req_size('0), .req_cmd('0),
    .req_scmd('0), .req_stall(req_stall3),
    .req_flush('0), .res_flush_ok(res_flush_ok3),
    .res_valid(res_valid3), .res_cmd(res_cmd3),
    .res_scmd(res_scmd3), .res_data(res_data3),
    .res_rtnctl(res_rtnctl3), .res_stall('0),
    .mc(mc3.master), .err_unroutable(err3)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic count_grants(input int r, output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!req_stall[r]) n++;
      @(negedge clock);
    end
  endtask

  initial begin
    req_valid = '0; req_flush = '0; res_stall = '0;
    req_rtnctl = '0; req_data = '0; req_addr = '0;
    req_size = '0; req_cmd = '0; req_scmd = '0;
    mc.mc_req_stall = 1'b0; mc.mc_res_valid = 1'b0;
    mc.mc_res_cmd = '0; mc.mc_res_scmd = '0;
    mc.mc_res_data = '0; mc.mc_res_rtnctl = '0;
    mc.mc_res_flush_ok = 1'b0;
    mc3.mc_req_stall = 1'b0; mc3.mc_res_valid = 1'b0;
    mc3.mc_res_cmd = '0; mc3.mc_res_scmd = '0;
    mc3.mc_res_data = '0; mc3.mc_res_rtnctl = '0;
    mc3.mc_res_flush_ok = 1'b0;

    // reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_valid", mc.mc_req_valid, 0);
    check("rst_rtnctl", mc.mc_req_rtnctl, 0);
    check("rst_addr", mc.mc_req_addr, 0);
    check("rst_flush", mc.mc_req_flush, 0);
    check("rst_flush_ok", res_flush_ok, 0);
    check("rst_err", err, 0);
    check("rst_err3", err3, 0);
    reset = 1'b0;

    // single requester
    @(negedge clock);
    req_valid = 4'b0001;
    req_rtnctl[31:0] = 32'h5;
    req_addr[47:0] = 48'h1000;
    req_data[63:0] = 64'h1122_3344_5566_7788;
    req_size[1:0] = 2'b11;
    req_cmd[2:0] = 3'd1;
    req_scmd[3:0] = 4'h9;
    #1 check("single_grant", req_stall, 4'b1110);
    @(negedge clock);
    req_valid = '0;
    check("single_valid", mc.mc_req_valid, 1);
    check("single_addr", mc.mc_req_addr, 48'h1000);
    check("single_rtnctl", mc.mc_req_rtnctl, 32'h5);
    check("single_data", mc.mc_req_data, 64'h1122_3344_5566_7788);
    check("single_size", mc.mc_req_size, 2'b11);
    check("single_cmd", mc.mc_req_cmd, 3'd1);
    check("single_scmd", mc.mc_req_scmd, 4'h9);
    @(negedge clock);
    check("single_empty", mc.mc_req_valid, 0);
    mc.mc_res_valid = 1'b1;
    mc.mc_res_rtnctl = 32'h5;
    mc.mc_res_data = 64'hCAFE;
    mc.mc_res_cmd = 3'd2;
    mc.mc_res_scmd = 4'h3;
    #1 check("resp_valid", res_valid, 4'b0001);
    check("resp_data", res_data, 64'hCAFE);
    check("resp_cmd", res_cmd, 3'd2);
    check("resp_scmd", res_scmd, 4'h3);
    check("resp_rtnctl", res_rtnctl, 32'h5);
    check("resp_nostall", mc.mc_res_stall, 0);
    @(negedge clock);
    mc.mc_res_valid = 1'b0;

    // round robin, then MC back-pressure
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_rtnctl[i*32 +: 32] = 32'hC000_0010 + 32'(i);
      req_addr[i*48 +: 48] = 48'h2000 + 48'(i * 16);
    end
    req_valid = 4'b1111;
    #1 check("rr_first", req_stall, 4'b1110);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("rr_valid", mc.mc_req_valid, 1);
      check("rr_rtnctl", mc.mc_req_rtnctl,
            (64'(k % 4) << 30) | (64'h10 + 64'(k % 4)));
    end
    mc.mc_req_stall = 1'b1;
    #1 check("stall_all", req_stall, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("hold_valid", mc.mc_req_valid, 1);
      check("hold_rtnctl", mc.mc_req_rtnctl, 32'h10);
      check("hold_addr", mc.mc_req_addr, 48'h2000);
      #1 check("hold_stall", req_stall, 4'b1111);
    end
    mc.mc_req_stall = 1'b0;
    req_valid = '0;
    @(negedge clock);
    check("drain_empty", mc.mc_req_valid, 0);

    // outstanding cap for requester 2
    do_reset();
    req_valid = 4'b0100;
    count_grants(2, g);
    check("cap_grants", g, 16);
    #1 check("cap_stall", req_stall, 4'b1111);
    mc.mc_res_valid = 1'b1;
    mc.mc_res_rtnctl = 32'h8000_0007;
    #1 check("cap_res_valid", res_valid, 4'b0100);
    check("cap_res_rtnctl", res_rtnctl, 32'h7);
    @(negedge clock);
    mc.mc_res_valid = 1'b0;
    #1 check("cap_resume", req_stall, 4'b1011);
    @(negedge clock);
    check("cap_tag", mc.mc_req_rtnctl[31:30], 2'd2);
    #1 check("cap_full", req_stall, 4'b1111);
    mc.mc_res_valid = 1'b1;
    mc.mc_res_rtnctl = 32'h8000_0008;
    @(negedge clock);
    mc.mc_res_valid = 1'b0;
    #1 check("same_cycle", req_stall, 4'b1011);
    @(negedge clock);
    #1 check("recap", req_stall, 4'b1111);
    req_valid = '0;

    // response back-pressure and unroutable tag
    @(negedge clock);
    mc.mc_res_valid = 1'b1;
    mc.mc_res_rtnctl = 32'hC000_0001;
    res_stall = 4'b1000;
    #1 check("rstall_up", mc.mc_res_stall, 1);
    check("rstall_valid", res_valid, 4'b1000);
    check("rstall_rtnctl", res_rtnctl, 32'h1);
    @(negedge clock);
    res_stall = '0;
    #1 check("rstall_down", mc.mc_res_stall, 0);
    @(negedge clock);
    mc.mc_res_valid = 1'b0;
    mc3.mc_res_valid = 1'b1;
    mc3.mc_res_rtnctl = 32'hC000_0000;
    #1 check("unr_stall", mc3.mc_res_stall, 0);
    check("unr_valid", res_valid3, 3'b000);
    @(negedge clock);
    mc3.mc_res_valid = 1'b0;
    check("unr_err", err3, 1);
    check("main_err", err, 0);
    @(negedge clock);
    check("unr_sticky", err3, 1);

    // two flushes served in turn
    do_reset();
    req_flush = 4'b1010;
    @(negedge clock);
    req_flush = '0;
    req_valid = 4'b0011;
    #1 check("fl_block1", req_stall, 4'b1110);
    check("fl_idle", mc.mc_req_flush, 0);
    @(negedge clock);
    check("fl_issue1", mc.mc_req_flush, 1);
    #1 check("fl_block1b", req_stall, 4'b1110);
    @(negedge clock);
    check("fl_wait1", mc.mc_req_flush, 0);
    #1 check("fl_block1c", req_stall, 4'b1110);
    mc.mc_res_flush_ok = 1'b1;
    @(negedge clock);
    mc.mc_res_flush_ok = 1'b0;
    check("fl_ok1", res_flush_ok, 4'b0010);
    #1 check("fl_unblock1", req_stall, 4'b1101);
    @(negedge clock);
    req_valid = '0;
    check("fl_ok1_once", res_flush_ok, 4'b0000);
    check("fl_issue3", mc.mc_req_flush, 1);
    @(negedge clock);
    check("fl_wait3", mc.mc_req_flush, 0);
    mc.mc_res_flush_ok = 1'b1;
    @(negedge clock);
    mc.mc_res_flush_ok = 1'b0;
    check("fl_ok3", res_flush_ok, 4'b1000);
    @(negedge clock);
    check("fl_ok3_once", res_flush_ok, 4'b0000);

    // reset in WAIT with requests outstanding
    do_reset();
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) @(negedge clock);
    req_valid = '0;
    req_flush = 4'b0100;
    @(negedge clock);
    req_flush = '0;
    @(negedge clock);
    check("rw_issue", mc.mc_req_flush, 1);
    @(negedge clock);
    reset = 1'b1;
    mc.mc_res_flush_ok = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    mc.mc_res_flush_ok = 1'b0;
    check("rw_no_ok", res_flush_ok, 0);
    check("rw_flush", mc.mc_req_flush, 0);
    check("rw_valid", mc.mc_req_valid, 0);
    @(negedge clock);
    check("rw_no_ok2", res_flush_ok, 0);
    check("rw_idle", mc.mc_req_flush, 0);
    req_valid = 4'b0001;
    count_grants(0, g);
    check("rw_cnt_clear", g, 16);
    req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
